mvp_run_controller: RTL and testbench
=====================================

# mvp_run_controller

Sequencing controller between the Module Validation Platform AXI4-Lite register bank and the module under validation (MUV). On a software start pulse it issues a configured number of operands to the MUV over a valid/ready request channel, waits for each result with a per-operand timeout, accumulates the results, and reports busy/done/timeout status and an interrupt back to the register bank.

## Interface
- DATA_WIDTH, 32, width of operands, results, base, stride and accumulator.
- CNT_WIDTH, 16, width of operand count and issued counter.
- TO_WIDTH, 20, width of timeout configuration and wait counter.

- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- start_pulse  in  1  one-cycle pulse from register bank (ctrl reg bit0 written 1).
- abort_pulse  in  1  one-cycle pulse (ctrl reg bit1 written 1).
- cfg_count  in  CNT_WIDTH  number of operands per run; sampled on accepted start.
- cfg_base  in  DATA_WIDTH  first operand value; sampled on accepted start.
- cfg_stride  in  DATA_WIDTH  operand increment; sampled on accepted start.
- cfg_timeout  in  TO_WIDTH  max WAIT cycles per result; 0 disables timeout; sampled on accepted start.
- m_valid  out  1  request valid to MUV.
- m_data  out  DATA_WIDTH  operand to MUV.
- m_ready  in  1  MUV accepts operand.
- s_valid  in  1  MUV result valid.
- s_data  in  DATA_WIDTH  MUV result.
- s_ready  out  1  controller accepts result.
- busy  out  1  run in progress.
- done  out  1  sticky; run finished (normally or by timeout).
- timeout_flag  out  1  sticky; run ended by timeout.
- issued_cnt  out  CNT_WIDTH  results received this run.
- result_acc  out  DATA_WIDTH  sum of results this run, mod 2^DATA_WIDTH.
- irq  out  1  one-cycle pulse at run completion (normal or timeout), not on abort.

## Operation
- Reset: state IDLE; every output 0; internal config, operand and wait counters 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: start_pulse (without abort_pulse) latches config, clears done, timeout_flag, issued_cnt, result_acc; loads operand register with cfg_base. If cfg_count==0 -> stay IDLE, set done, pulse irq, no MUV traffic. Else -> ISSUE.
- ISSUE: m_valid=1, m_data=operand register (stable while m_valid && !m_ready). On m_valid&&m_ready -> WAIT, operand register += stride (mod 2^DATA_WIDTH), wait counter cleared.
- WAIT: s_ready=1. On s_valid&&s_ready: result_acc += s_data, issued_cnt += 1; if new issued_cnt == latched count -> IDLE, done=1, irq pulse; else -> ISSUE. Without handshake, wait counter increments; when cfg_timeout!=0 and counter reaches cfg_timeout -> IDLE, done=1, timeout_flag=1, irq pulse.
- Exactly one operand outstanding at a time.
- start_pulse while busy: ignored; config changes during a run have no effect.
- abort_pulse in any state: next cycle IDLE, busy/m_valid/s_ready 0; done, timeout_flag stay 0; issued_cnt and result_acc hold values; no irq. abort_pulse with start_pulse in IDLE: abort wins, start ignored.
- ARESETN assertion mid-run: all outputs 0 immediately (async); no completion reported.
- issued_cnt at 2^CNT_WIDTH-1 cannot overflow: count is bounded by cfg_count.

## Timing
- All outputs registered; irq, done, busy change on the same edge.
- Start at edge T: busy=1 and m_valid=1 after edge T+1; m_data=cfg_base.
- Request handshake at edge k: m_valid=0, s_ready=1 from k+1.
- Result handshake at edge k: result_acc/issued_cnt updated at k+1; next m_valid=1 at k+1 or done/irq at k+1. Minimum 2 cycles per operand.
- Timeout: with cfg_timeout=N, s_ready held N cycles; if no s_valid in those N cycles, s_ready=0, busy=0, done=timeout_flag=1, irq=1 on the next edge. s_valid on the Nth cycle is accepted; handshake wins over timeout.
- cfg_count==0: done and irq at T+1, busy never asserted.

## Test plan
- Normal run: base=0x10, stride=4, count=3, MUV echoes operand+1 with m_ready/s_valid always 1 -> m_data 0x10,0x14,0x18; result_acc=0x3F; issued_cnt=3; done=1, irq one pulse, busy high 6 cycles.
- Backpressure: m_ready low 5 cycles then high, s_valid delayed 7 cycles, count=2 -> m_data stable while stalled, no timeout with cfg_timeout=0, result correct, done=1.
- Timeout: cfg_timeout=8, MUV never returns result -> s_ready high exactly 8 cycles, then done=1, timeout_flag=1, irq pulse, issued_cnt=0; s_valid on 8th cycle instead -> accepted, timeout_flag=0.
- Zero count and wrap: count=0 -> done+irq at T+1, no m_valid; base=0xFFFFFFFC, stride=4, count=2 -> m_data 0xFFFFFFFC then 0x00000000; results 0xFFFFFFFF and 2 -> result_acc=0x00000001.
- Abort/start collisions: abort in WAIT after 1 of 4 results -> IDLE next cycle, done=0, no irq, issued_cnt=1; start during busy ignored; start+abort same cycle in IDLE -> stays IDLE.
- Async reset mid-ISSUE: ARESETN low between edges -> m_valid, busy, all outputs 0 immediately; after release, new start runs from cfg_base.

Source files
------------

// File: rtl/mvp_run_controller.sv
// mvp_run_controller: sequences operand issue to the module under validation,
// collects one result per operand with an optional per-operand timeout, and
// reports run status and a completion interrupt to the register bank.
module mvp_run_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TO_WIDTH   = 20
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start_pulse,
  input  logic                  abort_pulse,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [DATA_WIDTH-1:0] cfg_base,
  input  logic [DATA_WIDTH-1:0] cfg_stride,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_flag,
  output logic [CNT_WIDTH-1:0]  issued_cnt,
  output logic [DATA_WIDTH-1:0] result_acc,
  output logic                  irq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_stride;
  logic [TO_WIDTH-1:0]   r_timeout;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [TO_WIDTH-1:0]   r_wait_cnt;
  logic                  r_m_valid;
  logic                  r_s_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_to_flag;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_irq;

  logic                  w_req_hs;
  logic                  w_rsp_hs;
  logic [CNT_WIDTH-1:0]  w_issued_nxt;
  logic [TO_WIDTH-1:0]   w_wait_nxt;
  logic                  w_to_hit;

  assign w_req_hs     = r_m_valid & m_ready;
  assign w_rsp_hs     = r_s_ready & s_valid;
  assign w_issued_nxt = r_issued + 1'b1;
  assign w_wait_nxt   = r_wait_cnt + 1'b1;
  // The cycle that would complete N idle WAIT cycles is the timeout cycle;
  // a result arriving in that same cycle is still taken (handshake checked first).
  assign w_to_hit     = (r_timeout != '0) && (w_wait_nxt == r_timeout);

  // Run-control FSM; every status output is a register updated here.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_stride   <= '0;
      r_timeout  <= '0;
      r_operand  <= '0;
      r_wait_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_s_ready  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_to_flag  <= 1'b0;
      r_issued   <= '0;
      r_acc      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (abort_pulse) begin
        // Abort drops the run silently: counters and accumulator keep their values.
        r_state   <= S_IDLE;
        r_m_valid <= 1'b0;
        r_s_ready <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_pulse) begin
              r_count    <= cfg_count;
              r_stride   <= cfg_stride;
              r_timeout  <= cfg_timeout;
              r_operand  <= cfg_base;
              r_wait_cnt <= '0;
              r_done     <= 1'b0;
              r_to_flag  <= 1'b0;
              r_issued   <= '0;
              r_acc      <= '0;
              if (cfg_count == '0) begin
                r_done <= 1'b1;
                r_irq  <= 1'b1;
              end else begin
                r_state   <= S_ISSUE;
                r_m_valid <= 1'b1;
                r_busy    <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            if (w_req_hs) begin
              r_state    <= S_WAIT;
              r_m_valid  <= 1'b0;
              r_s_ready  <= 1'b1;
              r_operand  <= r_operand + r_stride;
              r_wait_cnt <= '0;
            end
          end
          S_WAIT: begin
            if (w_rsp_hs) begin
              r_acc     <= r_acc + s_data;
              r_issued  <= w_issued_nxt;
              r_s_ready <= 1'b0;
              if (w_issued_nxt == r_count) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_irq   <= 1'b1;
              end else begin
                r_state   <= S_ISSUE;
                r_m_valid <= 1'b1;
              end
            end else if (w_to_hit) begin
              r_state   <= S_IDLE;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_to_flag <= 1'b1;
              r_irq     <= 1'b1;
            end else begin
              r_wait_cnt <= w_wait_nxt;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_valid      = r_m_valid;
  assign m_data       = r_operand;
  assign s_ready      = r_s_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_flag = r_to_flag;
  assign issued_cnt   = r_issued;
  assign result_acc   = r_acc;
  assign irq          = r_irq;

endmodule

// File: tb/tb_mvp_run_controller.sv
// Bench for mvp_run_controller: a small MUV model answers requests, expected
// operands are queued at start and popped on each request handshake.
module tb_mvp_run_controller;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TW = 20;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          start_pulse = 1'b0;
  logic          abort_pulse = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [DW-1:0] cfg_base = '0;
  logic [DW-1:0] cfg_stride = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          busy;
  logic          done;
  logic          timeout_flag;
  logic [CW-1:0] issued_cnt;
  logic [DW-1:0] result_acc;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_op_q[$];
  logic [DW-1:0] res_tab_q[$];
  logic [DW-1:0] acc_model;
  int            cnt_model;

  mvp_run_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .cfg_count(cfg_count), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_timeout(cfg_timeout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .done(done), .timeout_flag(timeout_flag),
    .issued_cnt(issued_cnt), .result_acc(result_acc), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Configure, queue the expected operand sequence, and pulse start for one cycle.
  task automatic do_start(input int cnt, input logic [DW-1:0] base,
                          input logic [DW-1:0] stride, input int to);
    cfg_count   = CW'(cnt);
    cfg_base    = base;
    cfg_stride  = stride;
    cfg_timeout = TW'(to);
    exp_op_q.delete();
    for (int i = 0; i < cnt; i++) exp_op_q.push_back(base + DW'(i) * stride);
    acc_model   = '0;
    cnt_model   = 0;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  // MUV model: stalls m_ready rdy_dly cycles per request, returns a result
  // res_dly s_ready cycles later (operand+1 unless res_tab_q supplies one).
  task automatic run_muv(input int rdy_dly, input int res_dly, input bit no_res,
                         input int budget, output int busy_cyc, output int irq_cnt,
                         output int srdy_cyc, output bit finished);
    int stall = 0;
    int wcnt = 0;
    bit held_v = 0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] pend = '0;
    logic [DW-1:0] exp;
    busy_cyc = 0; irq_cnt = 0; srdy_cyc = 0; finished = 0;
    for (int c = 0; c < budget; c++) begin
      if (busy) busy_cyc++;
      if (irq) irq_cnt++;
      if (s_ready) srdy_cyc++;
      if (done && !busy) begin
        finished = 1;
        break;
      end
      m_ready = 1'b0;
      s_valid = 1'b0;
      if (m_valid) begin
        if (held_v) begin
          n_cmp++;
          if (m_data !== held) begin
            n_err++;
            $display("FAIL m_data_stable: got %h required %h", m_data, held);
          end
        end
        held = m_data; held_v = 1;
        if (stall >= rdy_dly) begin
          m_ready = 1'b1;
          stall = 0; held_v = 0; wcnt = 0;
          n_cmp++;
          if (exp_op_q.size() == 0) begin
            n_err++;
            $display("FAIL m_data_extra: got %h required no request", m_data);
          end else begin
            exp = exp_op_q.pop_front();
            if (m_data !== exp) begin
              n_err++;
              $display("FAIL m_data: got %h required %h", m_data, exp);
            end
          end
          pend = (res_tab_q.size() != 0) ? res_tab_q.pop_front() : m_data + 1;
        end else stall++;
      end
      if (s_ready) begin
        if (!no_res && wcnt >= res_dly) begin
          s_valid = 1'b1;
          s_data  = pend;
          acc_model = acc_model + pend;
          cnt_model++;
          wcnt = 0;
        end else wcnt++;
      end
      tick();
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL run_finish: got still busy after %0d cycles required done", budget);
    end
  endtask

  task automatic check_end(input string nm, input bit exp_to);
    n_cmp++;
    if (result_acc !== acc_model) begin
      n_err++;
      $display("FAIL %s_acc: got %h required %h", nm, result_acc, acc_model);
    end
    n_cmp++;
    if (issued_cnt !== CW'(cnt_model)) begin
      n_err++;
      $display("FAIL %s_cnt: got %0d required %0d", nm, issued_cnt, cnt_model);
    end
    n_cmp++;
    if (done !== 1'b1 || timeout_flag !== exp_to) begin
      n_err++;
      $display("FAIL %s_status: got done=%b to=%b required done=1 to=%b",
               nm, done, timeout_flag, exp_to);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({m_valid, s_ready, busy, done, timeout_flag, irq} !== 6'b0 ||
        issued_cnt !== '0 || result_acc !== '0 || m_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got mv=%b sr=%b b=%b d=%b to=%b irq=%b cnt=%0d acc=%h md=%h required all 0",
               m_valid, s_ready, busy, done, timeout_flag, irq, issued_cnt, result_acc, m_data);
    end
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    int bc, ic, sc; bit fin;
    do_start(3, 32'h10, 32'h4, 0);
    n_cmp++;
    if (busy !== 1'b1 || m_valid !== 1'b1 || m_data !== 32'h10) begin
      n_err++;
      $display("FAIL normal_first: got b=%b mv=%b md=%h required 1 1 00000010", busy, m_valid, m_data);
    end
    run_muv(0, 0, 0, 50, bc, ic, sc, fin);
    check_end("normal", 1'b0);
    n_cmp++;
    if (result_acc !== 32'h3F) begin
      n_err++;
      $display("FAIL normal_acc_const: got %h required 0000003f", result_acc);
    end
    n_cmp++;
    if (bc != 6 || ic != 1) begin
      n_err++;
      $display("FAIL normal_timing: got busy=%0d irq=%0d required busy=6 irq=1", bc, ic);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL normal_sticky: got irq=%b done=%b required irq=0 done=1", irq, done);
    end
  endtask

  task automatic test_backpressure();
    int bc, ic, sc; bit fin;
    do_start(2, 32'h100, 32'h8, 0);
    run_muv(5, 7, 0, 100, bc, ic, sc, fin);
    check_end("bp", 1'b0);
    n_cmp++;
    if (exp_op_q.size() != 0 || ic != 1) begin
      n_err++;
      $display("FAIL bp_ops: got %0d left irq=%0d required 0 left irq=1", exp_op_q.size(), ic);
    end
  endtask

  task automatic test_timeout();
    int bc, ic, sc; bit fin;
    do_start(1, 32'h55, 32'h1, 8);
    run_muv(0, 0, 1, 50, bc, ic, sc, fin);
    check_end("to", 1'b1);
    n_cmp++;
    if (sc != 8 || ic != 1 || issued_cnt !== '0) begin
      n_err++;
      $display("FAIL to_window: got s_ready=%0d irq=%0d cnt=%0d required 8 1 0", sc, ic, issued_cnt);
    end
    do_start(1, 32'h55, 32'h1, 8);
    run_muv(0, 7, 0, 50, bc, ic, sc, fin);
    check_end("to_edge", 1'b0);
    n_cmp++;
    if (sc != 8 || issued_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL to_edge_window: got s_ready=%0d cnt=%0d required 8 1", sc, issued_cnt);
    end
  endtask

  task automatic test_zero_and_wrap();
    int bc, ic, sc; bit fin;
    do_start(0, 32'h20, 32'h1, 0);
    n_cmp++;
    if (done !== 1'b1 || irq !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_count: got d=%b irq=%b b=%b mv=%b required 1 1 0 0", done, irq, busy, m_valid);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after: got irq=%b mv=%b required 0 0", irq, m_valid);
    end
    res_tab_q.delete();
    res_tab_q.push_back(32'hFFFFFFFF);
    res_tab_q.push_back(32'h2);
    do_start(2, 32'hFFFFFFFC, 32'h4, 0);
    run_muv(0, 0, 0, 50, bc, ic, sc, fin);
    check_end("wrap", 1'b0);
    n_cmp++;
    if (result_acc !== 32'h1) begin
      n_err++;
      $display("FAIL wrap_acc_const: got %h required 00000001", result_acc);
    end
  endtask

  task automatic test_abort_collisions();
    int bc, ic, sc; bit fin;
    do_start(4, 32'h40, 32'h1, 0);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h7; tick(); s_valid = 1'b0;
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup: got s_ready=%b required 1", s_ready);
    end
    abort_pulse = 1'b1; tick(); abort_pulse = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0 ||
        irq !== 1'b0 || timeout_flag !== 1'b0 || issued_cnt !== 16'd1 || result_acc !== 32'h7) begin
      n_err++;
      $display("FAIL abort_state: got b=%b sr=%b mv=%b d=%b irq=%b to=%b cnt=%0d acc=%h required 0 0 0 0 0 0 1 7",
               busy, s_ready, m_valid, done, irq, timeout_flag, issued_cnt, result_acc);
    end
    start_pulse = 1'b1; abort_pulse = 1'b1; tick();
    start_pulse = 1'b0; abort_pulse = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || irq !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort: got b=%b mv=%b irq=%b d=%b required 0 0 0 0", busy, m_valid, irq, done);
    end
    do_start(2, 32'h200, 32'h10, 0);
    cfg_base = 32'h999; cfg_stride = 32'h1; cfg_count = 16'd5;
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    run_muv(0, 0, 0, 50, bc, ic, sc, fin);
    check_end("busy_start", 1'b0);
  endtask

  task automatic test_async_reset();
    int bc, ic, sc; bit fin;
    do_start(3, 32'h300, 32'h1, 0);
    #2 ARESETN = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, s_ready, busy, done, timeout_flag, irq} !== 6'b0 ||
        issued_cnt !== '0 || result_acc !== '0) begin
      n_err++;
      $display("FAIL async_reset: got mv=%b sr=%b b=%b d=%b to=%b irq=%b required all 0",
               m_valid, s_ready, busy, done, timeout_flag, irq);
    end
    tick();
    ARESETN = 1'b1;
    tick();
    do_start(2, 32'h500, 32'h2, 0);
    n_cmp++;
    if (m_data !== 32'h500 || m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_start: got md=%h mv=%b required 00000500 1", m_data, m_valid);
    end
    run_muv(0, 0, 0, 50, bc, ic, sc, fin);
    check_end("post_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_zero_and_wrap();
    test_abort_collisions();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
